shift_add_multiplier: RTL

- Sequential unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial-product addition per clock.
- Sits directly downstream of the WIDTH-bit ripple-carry adder and consumes its sum and carry-out every RUN cycle. The adder is instantiated inside this block.
- Operands arrive on a valid/ready start handshake. The product is returned on a valid/ready done handshake and held until consumed.

---
 rtl/shift_add_multiplier.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose:
//   Sequential unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH. Each clock in
//   RUN performs one partial-product addition through an internal
//   WIDTH-bit ripple-carry adder. After the addition, {carry, sum, lo} is
//   shifted right by one bit.
//   Operands enter on a valid/ready start handshake. The product leaves on a
//   valid/ready done handshake and is held until the consumer takes it.
//
// Optional feature (macro SHIFT_ADD_EARLY_EXIT_EN):
//   When defined, RUN ends as soon as the unprocessed multiplier bits are all
//   zero. The product value is the same; only the latency is shorter.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start_valid  operands a/b are presented
//   start_ready  block can accept operands (high only in IDLE)
//   a, b         multiplicand / multiplier, unsigned, WIDTH bits
//   done_valid   prod holds a valid result (high only in DONE)
//   done_ready   consumer takes the result
//   prod         product a*b, 2*WIDTH bits, held until the next result
//   busy         high while in RUN
// ---------------------------------------------------------------------------

module ripple_carry_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = c_i;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign c_o = carry[WIDTH];

endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done_valid,
   input  logic               done_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   // The multiplicand is added only when the current multiplier bit is set.
   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry;

   assign addend = lo_q[0] ? mcand_q : '0;

   ripple_carry_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a_i   (hi_q),
      .b_i   (addend),
      .c_i   (1'b0),
      .sum_o (sum),
      .c_o   (carry)
   );

`ifdef SHIFT_ADD_EARLY_EXIT_EN
   // After cnt steps, the low WIDTH-cnt bits of lo are the multiplier bits
   // still to be processed. The upper cnt bits of lo are already product
   // bits. If all pending bits are zero, {hi, lo} shifted right by
   // WIDTH-cnt is the final product.
   logic [WIDTH-1:0]     pend_mask;
   logic                 early_exit;
   logic [2*WIDTH-1:0]   partial;

   assign pend_mask  = {WIDTH{1'b1}} >> cnt_q;
   assign early_exit = ((lo_q & pend_mask) == '0);
   assign partial    = {hi_q, lo_q} >> (CW'(WIDTH) - cnt_q);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      prod_d      = prod_q;
      start_ready = 1'b0;
      done_valid  = 1'b0;
      busy        = 1'b0;

      case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            busy  = 1'b1;
            // The carry-out becomes the MSB of hi, so no addition bit is lost.
            hi_d  = {carry, sum[WIDTH-1:1]};
            lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
`ifdef SHIFT_ADD_EARLY_EXIT_EN
            if (early_exit) begin
               prod_d  = partial;
               state_d = DONE;
            end else if (cnt_q == LAST_STEP) begin
               prod_d  = {carry, sum, lo_q[WIDTH-1:1]};
               state_d = DONE;
            end
`else
            if (cnt_q == LAST_STEP) begin
               prod_d  = {carry, sum, lo_q[WIDTH-1:1]};
               state_d = DONE;
            end
`endif
         end

         DONE: begin
            done_valid = 1'b1;
            // start_ready stays low here, so a job can never be accepted in
            // the same cycle as the done handshake.
            if (done_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign prod = prod_q;

endmodule
